// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port among NREQ requesters, with an
// optional locked grant that is capped at MAX_HOLD completed accesses.
module ram_arbiter #(
  parameter int NREQ     = 3,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [NREQ-1:0]    req_ren,
  input  logic [NREQ-1:0]    req_wen,
  input  logic [NREQ-1:0]    req_lock,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_store,
  output logic [NREQ-1:0]    req_done,
  output logic [DW-1:0]      req_load,
  output logic [NREQ-1:0]    gnt,
  output logic               ram_ren,
  output logic               ram_wen,
  output logic [AW-1:0]      ram_addr,
  output logic [DW-1:0]      ram_store,
  input  logic [DW-1:0]      ram_load,
  input  logic               ram_ready,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]   MAX_HOLD_W = HW'(MAX_HOLD);
  localparam logic [NREQ-1:0] ONE_HOT0   = NREQ'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;

  logic [AW-1:0]   addr_a  [NREQ];
  logic [DW-1:0]   store_a [NREQ];
  logic [NREQ-1:0] active;
  logic            g_active;
  logic            g_lock;
  logic [IW-1:0]   next_ptr;
  logic [HW-1:0]   hold_inc;
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic            in_access;
  logic            done;

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign addr_a[i]  = req_addr[i*AW +: AW];
    assign store_a[i] = req_store[i*DW +: DW];
  end

  assign active   = req_ren | req_wen;
  assign g_active = active[gidx_q];
  assign g_lock   = req_lock[gidx_q];
  assign next_ptr = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + IW'(1);
  assign hold_inc = hold_cnt_q + HW'(1);

  // First active requester starting at rr_ptr, wrapping modulo NREQ.
  always_comb begin
    int idx;
    pick_valid = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!pick_valid && active[IW'(idx)]) begin
        pick_valid = 1'b1;
        pick_idx   = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gidx_d     = gidx_q;
    gnt_d      = gnt_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d    = ACCESS;
          gidx_d     = pick_idx;
          gnt_d      = ONE_HOT0 << pick_idx;
          hold_cnt_d = '0;
        end
      end
      ACCESS: begin
        // A dropped request wins over a coincident ram_ready (abort).
        if (!g_active) begin
          state_d  = IDLE;
          gnt_d    = '0;
          rr_ptr_d = next_ptr;
        end else if (ram_ready) begin
          hold_cnt_d = hold_inc;
          if (g_lock && (hold_inc < MAX_HOLD_W)) begin
            state_d = LOCKED;
          end else begin
            state_d  = IDLE;
            gnt_d    = '0;
            rr_ptr_d = next_ptr;
          end
        end
      end
      LOCKED: begin
        if (g_active) begin
          state_d = ACCESS;
        end else if (!g_lock) begin
          state_d  = IDLE;
          gnt_d    = '0;
          rr_ptr_d = next_ptr;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      gidx_q     <= '0;
      gnt_q      <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gidx_q     <= gidx_d;
      gnt_q      <= gnt_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign in_access = (state_q == ACCESS);
  assign done      = in_access && g_active && ram_ready;

  assign ram_wen   = in_access & req_wen[gidx_q];
  assign ram_ren   = in_access & req_ren[gidx_q] & ~req_wen[gidx_q];
  assign ram_addr  = in_access ? addr_a[gidx_q]  : '0;
  assign ram_store = in_access ? store_a[gidx_q] : '0;
  assign req_done  = done ? gnt_q : '0;
  assign req_load  = done ? ram_load : '0;
  assign gnt       = gnt_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule
